// File: rtl/params_pkg.sv
// Shared constants, framer state encoding and the residual-to-tkeep map
// used by the S2MM traffic framer.
package params_pkg;

  localparam int DATA_WIDTH = 32;
  localparam int KEEP_WIDTH = DATA_WIDTH / 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } framer_state_e;

  // Byte enables for the final beat; residual 0 means the last word is full.
  function automatic logic [3:0] keep_from_residual(input logic [1:0] residual);
    logic [3:0] keep;
    case (residual)
      2'd1:    keep = 4'b0001;
      2'd2:    keep = 4'b0011;
      2'd3:    keep = 4'b0111;
      default: keep = 4'b1111;
    endcase
    return keep;
  endfunction

endpackage

// File: rtl/axis_sync_fifo.sv
// Synchronous FIFO with a registered head word (no fall-through combinational
// path from the write port), full/empty flags and async active-high reset.
module axis_sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [AW-1:0]    rd_ptr_nxt_s;
  logic [AW:0]      count_r;
  logic [WIDTH-1:0] head_r;
  logic             wr_s;
  logic             rd_s;

  assign full         = (count_r == (AW+1)'(DEPTH));
  assign empty        = (count_r == (AW+1)'(0));
  assign wr_s         = wr_en && !full;
  assign rd_s         = rd_en && !empty;
  assign rd_ptr_nxt_s = rd_ptr_r + AW'(1);
  assign rd_data      = head_r;

  // Storage array; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (wr_s) begin
      mem_r[wr_ptr_r] <= wr_data;
    end
  end

  // Pointers and occupancy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (wr_s) wr_ptr_r <= wr_ptr_r + AW'(1);
      if (rd_s) rd_ptr_r <= rd_ptr_nxt_s;
      case ({wr_s, rd_s})
        2'b10:   count_r <= count_r + (AW+1)'(1);
        2'b01:   count_r <= count_r - (AW+1)'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Head register: prefetch the next entry on a pop, or capture the write
  // when it lands in an empty (or emptying) FIFO.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_r <= '0;
    end else if (rd_s) begin
      if (count_r == (AW+1)'(1)) begin
        if (wr_s) head_r <= wr_data;
      end else begin
        head_r <= mem_r[rd_ptr_nxt_s];
      end
    end else if (wr_s && empty) begin
      head_r <= wr_data;
    end
  end

endmodule

// File: rtl/axis_s2mm_framer.sv
// Frames raw source words into one AXI4-Stream packet of a programmed byte
// length for the DMA S2MM port. Define AXIS_FRAMER_STATS_EN for statistics.
module axis_s2mm_framer #(
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 16,
  parameter int LEN_WIDTH  = 16
) (
  input  logic                  axi_aclk,
  input  logic                  axi_reset,
  input  logic                  start,
  input  logic [LEN_WIDTH-1:0]  pkt_len,
  output logic                  busy,
  output logic                  done,
  output logic                  len_err,
  input  logic [DATA_WIDTH-1:0] src_data,
  input  logic                  src_valid,
  output logic                  src_ready,
  output logic [DATA_WIDTH-1:0] s_axis_s2mm_tdata,
  output logic [3:0]            s_axis_s2mm_tkeep,
  output logic                  s_axis_s2mm_tvalid,
  input  logic                  s_axis_s2mm_tready,
  output logic                  s_axis_s2mm_tlast
`ifdef AXIS_FRAMER_STATS_EN
  ,
  output logic [15:0]           pkt_count,
  output logic [31:0]           stall_count
`endif
);

  import params_pkg::*;

  localparam int CW = LEN_WIDTH - 1;

  framer_state_e         state_r;
  framer_state_e         state_nxt_s;
  logic [CW-1:0]         in_left_r;
  logic [CW-1:0]         out_left_r;
  logic [CW-1:0]         beats_s;
  logic [LEN_WIDTH:0]    len_plus3_s;
  logic [1:0]            residual_r;
  logic                  len_err_r;
  logic                  start_ok_s;
  logic                  wr_en_s;
  logic                  rd_en_s;
  logic                  fifo_full_s;
  logic                  fifo_empty_s;
  logic [DATA_WIDTH-1:0] fifo_dout_s;

  // ceil(pkt_len/4) without a divider
  assign len_plus3_s = {1'b0, pkt_len} + (LEN_WIDTH+1)'(3);
  assign beats_s     = len_plus3_s[LEN_WIDTH:2];
  assign start_ok_s  = start && (state_r == IDLE) && (pkt_len != '0);

  assign busy               = (state_r != IDLE);
  assign done               = (state_r == DONE);
  assign len_err            = len_err_r;
  assign src_ready          = (state_r == RUN) && (in_left_r != '0) && !fifo_full_s;
  assign s_axis_s2mm_tvalid = (state_r == RUN) && !fifo_empty_s;
  assign s_axis_s2mm_tlast  = s_axis_s2mm_tvalid && (out_left_r == CW'(1));
  assign s_axis_s2mm_tdata  = fifo_dout_s;
  assign s_axis_s2mm_tkeep  = !s_axis_s2mm_tvalid ? 4'b0000 :
                              s_axis_s2mm_tlast   ? keep_from_residual(residual_r) : 4'b1111;
  assign wr_en_s            = src_valid && src_ready;
  assign rd_en_s            = s_axis_s2mm_tvalid && s_axis_s2mm_tready;

  axis_sync_fifo #(
    .WIDTH (DATA_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (axi_aclk),
    .rst     (axi_reset),
    .wr_en   (wr_en_s),
    .wr_data (src_data),
    .rd_en   (rd_en_s),
    .rd_data (fifo_dout_s),
    .full    (fifo_full_s),
    .empty   (fifo_empty_s)
  );

  // Next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (start_ok_s) state_nxt_s = RUN;
        else            state_nxt_s = IDLE;
      end
      RUN: begin
        if (rd_en_s && s_axis_s2mm_tlast) state_nxt_s = DONE;
        else                              state_nxt_s = RUN;
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // State, beat counters and the latched residual.
  always_ff @(posedge axi_aclk or posedge axi_reset) begin
    if (axi_reset) begin
      state_r    <= IDLE;
      in_left_r  <= '0;
      out_left_r <= '0;
      residual_r <= 2'd0;
      len_err_r  <= 1'b0;
    end else begin
      state_r   <= state_nxt_s;
      len_err_r <= start && (state_r == IDLE) && (pkt_len == '0);
      if (start_ok_s) begin
        in_left_r  <= beats_s;
        out_left_r <= beats_s;
        residual_r <= pkt_len[1:0];
      end else begin
        if (wr_en_s) in_left_r  <= in_left_r - CW'(1);
        if (rd_en_s) out_left_r <= out_left_r - CW'(1);
      end
    end
  end

`ifdef AXIS_FRAMER_STATS_EN
  logic [15:0] pkt_count_r;
  logic [31:0] stall_count_r;

  assign pkt_count   = pkt_count_r;
  assign stall_count = stall_count_r;

  // Packet counter wraps; stall counter saturates.
  always_ff @(posedge axi_aclk or posedge axi_reset) begin
    if (axi_reset) begin
      pkt_count_r   <= 16'd0;
      stall_count_r <= 32'd0;
    end else begin
      if (state_r == DONE) pkt_count_r <= pkt_count_r + 16'd1;
      if (s_axis_s2mm_tvalid && !s_axis_s2mm_tready && (stall_count_r != 32'hFFFF_FFFF))
        stall_count_r <= stall_count_r + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_axis_s2mm_framer.sv
// Randomized self-checking bench for axis_s2mm_framer; expected beats come
// from a packet-level model (word list, beat count, residual keep).
module tb_axis_s2mm_framer;

  logic        axi_aclk = 1'b0;
  logic        axi_reset;
  logic        start;
  logic [15:0] pkt_len;
  logic        busy;
  logic        done;
  logic        len_err;
  logic [31:0] src_data;
  logic        src_valid;
  logic        src_ready;
  logic [31:0] s_axis_s2mm_tdata;
  logic [3:0]  s_axis_s2mm_tkeep;
  logic        s_axis_s2mm_tvalid;
  logic        s_axis_s2mm_tready;
  logic        s_axis_s2mm_tlast;
`ifdef AXIS_FRAMER_STATS_EN
  logic [15:0] pkt_count;
  logic [31:0] stall_count;
`endif

  int checks = 0;
  int errors = 0;

  always #5 axi_aclk = ~axi_aclk;

  axis_s2mm_framer dut (
    .axi_aclk           (axi_aclk),
    .axi_reset          (axi_reset),
    .start              (start),
    .pkt_len            (pkt_len),
    .busy               (busy),
    .done               (done),
    .len_err            (len_err),
    .src_data           (src_data),
    .src_valid          (src_valid),
    .src_ready          (src_ready),
    .s_axis_s2mm_tdata  (s_axis_s2mm_tdata),
    .s_axis_s2mm_tkeep  (s_axis_s2mm_tkeep),
    .s_axis_s2mm_tvalid (s_axis_s2mm_tvalid),
    .s_axis_s2mm_tready (s_axis_s2mm_tready),
    .s_axis_s2mm_tlast  (s_axis_s2mm_tlast)
`ifdef AXIS_FRAMER_STATS_EN
    ,
    .pkt_count          (pkt_count),
    .stall_count        (stall_count)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge axi_aclk);
    #1;
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_busy"},   busy, 32'd0);
    chk({tag, "_done"},   done, 32'd0);
    chk({tag, "_lenerr"}, len_err, 32'd0);
    chk({tag, "_srcrdy"}, src_ready, 32'd0);
    chk({tag, "_tvalid"}, s_axis_s2mm_tvalid, 32'd0);
    chk({tag, "_tlast"},  s_axis_s2mm_tlast, 32'd0);
    chk({tag, "_tdata"},  s_axis_s2mm_tdata, 32'd0);
    chk({tag, "_tkeep"},  s_axis_s2mm_tkeep, 32'd0);
  endtask

  // Byte enables of a beat: full, or low (len mod 4) bytes on the final beat.
  function automatic logic [3:0] exp_keep(input int len, input bit last);
    int r;
    r = len % 4;
    if (!last || r == 0) return 4'hF;
    return 4'((1 << r) - 1);
  endfunction

  // One packet: pv/pr = percent chance of src_valid/tready, stall = cycles of
  // forced tready low once data is offered, abort_at = reset after that many
  // beats, inject = pulse a zero-length start mid-packet.
  task automatic run_packet(input int len, input int pv, input int pr, input int stall,
                            input int abort_at, input bit inject);
    logic [31:0] words [$];
    logic [31:0] exp_w;
    logic [31:0] p_data;
    logic [3:0]  p_keep;
    logic        p_last;
    int nb, idx, beats, cyc, stall_left, first_hs, last_hs;
    bit seen_done, prev_stall;
    nb = (len + 3) / 4;
    for (int i = 0; i < nb + 4; i++) words.push_back($urandom);
    idx = 0; beats = 0; cyc = 0; stall_left = stall;
    first_hs = -1; last_hs = -1; seen_done = 1'b0; prev_stall = 1'b0;
    p_data = 32'd0; p_keep = 4'd0; p_last = 1'b0;

    start = 1'b1; pkt_len = 16'(len); src_valid = 1'b0; s_axis_s2mm_tready = 1'b0;
    step();
    start = 1'b0;
    chk("busy_after_start", busy, 32'd1);

    while (!seen_done && cyc < 3000) begin
      if (abort_at > 0 && beats == abort_at) begin
        src_valid = 1'b0; s_axis_s2mm_tready = 1'b0;
        axi_reset = 1'b1;
        #1;
        chk_idle_outputs("abort");
        step();
        axi_reset = 1'b0;
        for (int k = 0; k < 4; k++) begin
          step();
          chk("abort_no_done", done, 32'd0);
          chk("abort_not_busy", busy, 32'd0);
        end
        return;
      end
      if (done) begin
        seen_done = 1'b1;
        chk("beat_count", beats, nb);
        chk("done_after_tlast", last_hs, cyc - 1);
        chk("src_words_taken", idx, nb);
        chk("busy_in_done", busy, 32'd1);
        if (pv == 100 && pr == 100 && stall == 0)
          chk("back_to_back", last_hs - first_hs, nb - 1);
      end else begin
        if (prev_stall) begin
          chk("hold_tvalid", s_axis_s2mm_tvalid, 32'd1);
          chk("hold_tdata", s_axis_s2mm_tdata, p_data);
          chk("hold_tkeep", s_axis_s2mm_tkeep, p_keep);
          chk("hold_tlast", s_axis_s2mm_tlast, p_last);
        end
        if (inject && cyc == 3) chk("ignored_start_no_err", len_err, 32'd0);
        src_valid = ($urandom_range(99) < pv);
        src_data  = (idx < words.size()) ? words[idx] : 32'hDEAD_BEEF;
        s_axis_s2mm_tready = (stall_left > 0) ? 1'b0 : ($urandom_range(99) < pr);
        start   = inject && (cyc == 2);
        pkt_len = inject ? 16'd0 : 16'(len);
        #1;
        if (s_axis_s2mm_tvalid && s_axis_s2mm_tready) begin
          exp_w = (beats < words.size()) ? words[beats] : 32'hFFFF_FFFF;
          chk("tdata", s_axis_s2mm_tdata, exp_w);
          chk("tkeep", s_axis_s2mm_tkeep, exp_keep(len, beats == nb - 1));
          chk("tlast", s_axis_s2mm_tlast, (beats == nb - 1) ? 32'd1 : 32'd0);
          if (first_hs < 0) first_hs = cyc;
          if (s_axis_s2mm_tlast) last_hs = cyc;
          beats++;
        end
        if (src_valid && src_ready) idx++;
        if (stall_left > 0 && s_axis_s2mm_tvalid) begin
          stall_left--;
          if (stall_left == 0) begin
            chk("fifo_fill_words", idx, (nb < 16) ? nb : 16);
            chk("src_ready_when_full", src_ready, 32'd0);
          end
        end
        prev_stall = s_axis_s2mm_tvalid && !s_axis_s2mm_tready;
        p_data = s_axis_s2mm_tdata; p_keep = s_axis_s2mm_tkeep; p_last = s_axis_s2mm_tlast;
        step();
        cyc++;
      end
    end
    chk("done_seen", seen_done, 32'd1);
    src_valid = 1'b0; s_axis_s2mm_tready = 1'b0; start = 1'b0;
    step();
    chk("done_one_cycle", done, 32'd0);
    chk("idle_after_done", busy, 32'd0);
  endtask

  initial begin
    axi_reset = 1'b1; start = 1'b0; pkt_len = 16'd0;
    src_data = 32'd0; src_valid = 1'b0; s_axis_s2mm_tready = 1'b0;
    #1;
    chk_idle_outputs("reset");
    repeat (2) @(posedge axi_aclk);
    #1;
    axi_reset = 1'b0;
    step();

    start = 1'b1; pkt_len = 16'd0;
    step();
    start = 1'b0;
    chk("len_err_pulse", len_err, 32'd1);
    chk("len0_busy", busy, 32'd0);
    chk("len0_tvalid", s_axis_s2mm_tvalid, 32'd0);
    chk("len0_srcrdy", src_ready, 32'd0);
    step();
    chk("len_err_once", len_err, 32'd0);
    chk("len0_busy_after", busy, 32'd0);

    run_packet(16, 100, 100, 0, 0, 1'b0);
    run_packet(13, 100, 100, 0, 0, 1'b0);
    run_packet(7,  100, 100, 0, 0, 1'b0);
    run_packet(4,  100, 100, 0, 0, 1'b0);
    run_packet(40, 100, 100, 0, 0, 1'b1);

    axi_reset = 1'b1;
    step();
    axi_reset = 1'b0;
    step();
    run_packet(64, 100, 100, 20, 0, 1'b0);
`ifdef AXIS_FRAMER_STATS_EN
    chk("stall_count", stall_count, 32'd20);
    chk("pkt_count", pkt_count, 32'd1);
`endif

    run_packet(32, 100, 100, 0, 3, 1'b0);
`ifdef AXIS_FRAMER_STATS_EN
    chk("pkt_count_after_reset", pkt_count, 32'd0);
`endif
    run_packet(8, 100, 100, 0, 0, 1'b0);

    for (int t = 0; t < 12; t++)
      run_packet($urandom_range(80, 1), $urandom_range(100, 30), $urandom_range(100, 30),
                 0, 0, (t % 3) == 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
